// File: rtl/rv_test_monitor.sv
// riscv-tests verdict monitor: shadows gp (x3) and reports pass/fail/timeout on ECALL.
// Define RV_MON_REGSHADOW_EN for a full 32x32 register shadow with a dbg_sel/dbg_data read port.
module rv_test_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_valid,
  input  logic [31:0]      inst,
  input  logic             rd_we,
  input  logic [4:0]       rd_addr,
  input  logic [31:0]      rd_data,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [30:0]      fail_test,
  output logic [31:0]      gp_shadow,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
`ifdef RV_MON_REGSHADOW_EN
  ,
  input  logic [4:0]       dbg_sel,
  output logic [31:0]      dbg_data
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  localparam logic [31:0]      ECALL_WORD = 32'h0000_0073;
  localparam bit               TO_EN      = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state;

  logic             live;
  logic             is_ecall;
  logic             gp_wr;
  logic [31:0]      gp_eff;
  logic [CNT_W-1:0] cc_next;
  logic [CNT_W-1:0] ir_next;

  always_comb begin
    live     = (state == S_IDLE) || (state == S_RUN);
    is_ecall = inst_valid && (inst == ECALL_WORD);
    gp_wr    = rd_we && (rd_addr == 5'd3);
    // a gp write in the ECALL cycle is visible to the verdict
    gp_eff   = gp_wr ? rd_data : gp_shadow;
    cc_next  = (&cycle_count)   ? cycle_count   : cycle_count + CNT_W'(1);
    ir_next  = (&instret_count) ? instret_count : instret_count + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      fail_test     <= '0;
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (state == S_RUN)
        cycle_count <= cc_next;
      // the instruction that leaves IDLE is counted too
      if (live && inst_valid)
        instret_count <= ir_next;

      if (live && is_ecall) begin
        done <= 1'b1;
        if (gp_eff == 32'd1) begin
          state     <= S_PASS;
          pass      <= 1'b1;
          fail_test <= '0;
        end else begin
          state     <= S_FAIL;
          fail_test <= gp_eff[31:1];
        end
      end else if (state == S_IDLE && inst_valid) begin
        state <= S_RUN;
      end else if (state == S_RUN && TO_EN && cycle_count == TO_LAST) begin
        state   <= S_TIMEOUT;
        timeout <= 1'b1;
        done    <= 1'b1;
      end
    end
  end

`ifdef RV_MON_REGSHADOW_EN
  logic [31:0] regs [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (live && rd_we && rd_addr != 5'd0) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign gp_shadow = regs[3];
  assign dbg_data  = (dbg_sel == 5'd0) ? '0 : regs[dbg_sel];
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      gp_shadow <= '0;
    else if (live && gp_wr)
      gp_shadow <= rd_data;
  end
`endif

endmodule

// File: tb/tb_rv_test_monitor.sv
// Scoreboard bench for rv_test_monitor: stimulus pushes expected verdicts, a monitor pops them on done.
module tb_rv_test_monitor;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_valid = 1'b0;
  logic [31:0] inst = '0;
  logic        rd_we = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data = '0;

  logic        done, pass, timeout;
  logic [30:0] fail_test;
  logic [31:0] gp_shadow, cycle_count, instret_count;

  logic        s_done, s_pass, s_timeout;
  logic [30:0] s_fail_test;
  logic [31:0] s_gp_shadow;
  logic [3:0]  s_cycle_count, s_instret_count;

`ifdef RV_MON_REGSHADOW_EN
  logic [4:0]  dbg_sel = '0;
  logic [31:0] dbg_data, s_dbg_data;
`endif

  rv_test_monitor #(.TIMEOUT_CYCLES(20), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst(inst),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .done(done), .pass(pass), .timeout(timeout), .fail_test(fail_test),
    .gp_shadow(gp_shadow), .cycle_count(cycle_count), .instret_count(instret_count)
`ifdef RV_MON_REGSHADOW_EN
    , .dbg_sel(dbg_sel), .dbg_data(dbg_data)
`endif
  );

  rv_test_monitor #(.TIMEOUT_CYCLES(0), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst(inst),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .done(s_done), .pass(s_pass), .timeout(s_timeout), .fail_test(s_fail_test),
    .gp_shadow(s_gp_shadow), .cycle_count(s_cycle_count), .instret_count(s_instret_count)
`ifdef RV_MON_REGSHADOW_EN
    , .dbg_sel(dbg_sel), .dbg_data(s_dbg_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pass;
    logic        timeout;
    logic [30:0] fail_test;
    logic [31:0] instret;
    logic [31:0] cycles;
    logic [31:0] gp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  // Monitor: a rising done is the DUT's verdict; compare against the oldest expectation.
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".pass"},      64'(pass),          64'(e.pass));
        check({e.name, ".timeout"},   64'(timeout),       64'(e.timeout));
        check({e.name, ".fail_test"}, 64'(fail_test),     64'(e.fail_test));
        check({e.name, ".instret"},   64'(instret_count), 64'(e.instret));
        check({e.name, ".cycles"},    64'(cycle_count),   64'(e.cycles));
        check({e.name, ".gp"},        64'(gp_shadow),     64'(e.gp));
      end
    end
    done_q <= done;
  end

  task automatic step(input logic iv, input logic [31:0] iw, input logic we,
                      input logic [4:0] a, input logic [31:0] d);
    inst_valid = iv; inst = iw; rd_we = we; rd_addr = a; rd_data = d;
    @(negedge clk);
    inst_valid = 1'b0; inst = '0; rd_we = 1'b0; rd_addr = '0; rd_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input string nm, input logic p, input logic to, input logic [30:0] ft,
                      input logic [31:0] ir, input logic [31:0] cc, input logic [31:0] gp);
    exp_t e;
    e.name = nm; e.pass = p; e.timeout = to; e.fail_test = ft;
    e.instret = ir; e.cycles = cc; e.gp = gp;
    exp_q.push_back(e);
  endtask

  task automatic check_idle_zero(input string nm);
    check({nm, ".done"},    64'(done),          64'd0);
    check({nm, ".pass"},    64'(pass),          64'd0);
    check({nm, ".timeout"}, 64'(timeout),       64'd0);
    check({nm, ".ft"},      64'(fail_test),     64'd0);
    check({nm, ".gp"},      64'(gp_shadow),     64'd0);
    check({nm, ".cc"},      64'(cycle_count),   64'd0);
    check({nm, ".ir"},      64'(instret_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();
    check_idle_zero("reset");

    // Pass: 3 instructions, gp=1, ECALL
    for (int i = 0; i < 3; i++) step(1'b1, NOP, 1'b0, 5'd0, '0);
    step(1'b0, '0, 1'b1, 5'd3, 32'd1);
    push("pass", 1'b1, 1'b0, 31'd0, 32'd4, 32'd4, 32'd1);
    step(1'b1, ECALL, 1'b0, 5'd0, '0);
    step(1'b1, NOP, 1'b0, 5'd0, '0);
    check("pass_held.done", 64'(done), 64'd1);
    check("pass_held.ir",   64'(instret_count), 64'd4);

    // Fail: gp=0xB -> test 5; later gp writes ignored
    do_reset();
    step(1'b1, NOP, 1'b0, 5'd0, '0);
    step(1'b0, '0, 1'b1, 5'd3, 32'h0000_000B);
    push("fail", 1'b0, 1'b0, 31'd5, 32'd2, 32'd2, 32'h0000_000B);
    step(1'b1, ECALL, 1'b0, 5'd0, '0);
    step(1'b1, NOP, 1'b1, 5'd3, 32'h55);
    check("fail_frozen.gp", 64'(gp_shadow),     64'h0B);
    check("fail_frozen.ir", 64'(instret_count), 64'd2);
    check("fail_frozen.cc", 64'(cycle_count),   64'd2);

    // ECALL straight from IDLE with gp=0: fail, test 0
    do_reset();
    push("gp0", 1'b0, 1'b0, 31'd0, 32'd1, 32'd0, 32'd0);
    step(1'b1, ECALL, 1'b0, 5'd0, '0);

    // Same-cycle gp write wins; EBREAK/CSR and x5 write ignored
    do_reset();
    step(1'b0, '0, 1'b1, 5'd3, 32'd7);
    step(1'b1, NOP, 1'b0, 5'd0, '0);
    step(1'b1, 32'h0010_0073, 1'b1, 5'd5, 32'h99);
    step(1'b1, 32'h3000_2073, 1'b0, 5'd0, '0);
    check("sys_no_done", 64'(done), 64'd0);
    check("x5_no_gp",    64'(gp_shadow), 64'd7);
    push("same_cycle", 1'b1, 1'b0, 31'd0, 32'd4, 32'd3, 32'd1);
    step(1'b1, ECALL, 1'b1, 5'd3, 32'd1);

    // Timeout after 20 RUN cycles; the 4-bit, timeout-free instance saturates
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, NOP, 1'b0, 5'd0, '0);
    check("pre_to.done", 64'(done), 64'd0);
    check("pre_to.cc",   64'(cycle_count), 64'd19);
    push("timeout", 1'b0, 1'b1, 31'd0, 32'd21, 32'd20, 32'd0);
    for (int i = 0; i < 5 && !done; i++) step(1'b1, NOP, 1'b0, 5'd0, '0);
    check("sat.cc",   64'(s_cycle_count),   64'd15);
    check("sat.ir",   64'(s_instret_count), 64'd15);
    check("sat.done", 64'(s_done),          64'd0);

    // ECALL on the timeout boundary: ECALL wins
    do_reset();
    step(1'b0, '0, 1'b1, 5'd3, 32'd1);
    for (int i = 0; i < 20; i++) step(1'b1, NOP, 1'b0, 5'd0, '0);
    push("ecall_at_to", 1'b1, 1'b0, 31'd0, 32'd21, 32'd20, 32'd1);
    step(1'b1, ECALL, 1'b0, 5'd0, '0);

    // Asynchronous reset mid-run
    do_reset();
    step(1'b1, NOP, 1'b1, 5'd3, 32'd9);
    for (int i = 0; i < 9; i++) step(1'b1, NOP, 1'b0, 5'd0, '0);
    check("pre_rst.ir", 64'(instret_count), 64'd10);
    #2 reset = 1'b1;
    #1 check_idle_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, '0, 1'b0, 5'd0, '0);
    step(1'b0, '0, 1'b0, 5'd0, '0);
    check("post_rst.cc", 64'(cycle_count), 64'd0);
    step(1'b1, NOP, 1'b0, 5'd0, '0);
    step(1'b1, NOP, 1'b0, 5'd0, '0);
    check("restart.ir", 64'(instret_count), 64'd2);
    check("restart.cc", 64'(cycle_count),   64'd1);

`ifdef RV_MON_REGSHADOW_EN
    do_reset();
    step(1'b0, '0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    step(1'b0, '0, 1'b1, 5'd0, 32'h1234);
    dbg_sel = 5'd5;
    #1 check("dbg.x5", 64'(dbg_data), 64'hDEAD_BEEF);
    dbg_sel = 5'd0;
    #1 check("dbg.x0", 64'(dbg_data), 64'd0);
`endif

    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_test_monitor.md
Name: rv_test_monitor

Overview:
Synthesizable pass/fail monitor that sits directly downstream of the rv core. It consumes the core's instruction stream and register writeback port, and keeps a shadow of gp (x3). On ECALL it reports the riscv-tests verdict: pass when gp==1, otherwise failing test number gp>>1. It replaces simulator-only end-of-test checks so the same verdict logic runs on the bench and on hardware (LEDs/UART).

Parameters:
TIMEOUT_CYCLES, 5000, RUN-state cycles before a timeout is declared; 0 disables the timeout.
CNT_W, 32, width of the cycle and instret counters.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
inst_valid  in  1  inst holds an instruction entering execute this cycle
inst  in  32  instruction word
rd_we  in  1  register-file write strobe
rd_addr  in  5  destination register
rd_data  in  32  writeback data
done  out  1  verdict reached (pass, fail or timeout); sticky
pass  out  1  gp==1 at ECALL; sticky
timeout  out  1  TIMEOUT_CYCLES elapsed without ECALL; sticky
fail_test  out  31  gp[31:1] captured at ECALL; 0 on pass or timeout
gp_shadow  out  32  current shadow of x3
cycle_count  out  CNT_W  cycles spent in RUN, saturating
instret_count  out  CNT_W  inst_valid pulses in RUN, including the ECALL, saturating

Behaviour:
- reset (async, active-high): state=IDLE. All outputs, gp_shadow and counters = 0. Assertion mid-run aborts immediately. A sticky verdict is cleared only by reset.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal.
- IDLE -> RUN on the first inst_valid. That instruction is counted and may itself be an ECALL, which is evaluated in the same cycle.
- RUN:
  - cycle_count increments every clk.
  - instret_count increments on each inst_valid.
  - Both counters saturate at all-ones with no wrap.
- gp_shadow updates on rd_we && rd_addr==5'd3 in any non-terminal state. Writes to x0 and to other registers are ignored. Writes are frozen once terminal.
- ECALL detection: inst_valid && inst==32'h0000_0073 exactly.
  - Other SYSTEM-opcode words (EBREAK, CSR*) do not end the test.
- Verdict uses the effective gp. If a gp write and the ECALL occur in the same cycle, the new rd_data is used (write-before-check).
  - effective gp == 1: PASS; pass=1, fail_test=0.
  - otherwise: FAIL; fail_test=gp[31:1]. A gp of 0 gives fail_test=0 with pass=0.
- Latency: done, pass, fail_test and timeout are registered. They appear on the clk edge that samples the ECALL and are visible the cycle after the ECALL is presented.
- Timeout: if TIMEOUT_CYCLES!=0 and cycle_count reaches TIMEOUT_CYCLES-1 in RUN with no ECALL that cycle, go to TIMEOUT on the next edge; timeout=1, done=1.
  - If the ECALL and the timeout boundary coincide, the ECALL wins.
- Terminal states: counters frozen, inputs ignored, outputs held.

Optional Feature:
RV_MON_REGSHADOW_EN:
- Defined: adds input dbg_sel[4:0] and output dbg_data[31:0] (combinational read).
  - The monitor keeps a 32x32 shadow of every register written via rd_we.
  - x0 reads always 0.
  - Same gating as gp_shadow: frozen once terminal.
  - gp_shadow is then a view of shadow entry 3.
  - Lets the bench dump x0..x31 at done without hierarchical references into the core.
- Undefined: only the x3 shadow exists; the dbg_* ports are absent.

Test Plan:
- Pass: after reset, 3 instructions; write x3=1; then inst=0x00000073 -> next cycle done=1, pass=1, fail_test=0, instret_count=4.
- Fail: write x3=0x0000000B, then ECALL -> done=1, pass=0, fail_test=5; further rd_we to x3 leaves gp_shadow=0x0B.
- Same-cycle: x3 write of 1 in the same cycle as the ECALL, with prior gp=7 -> pass=1. Also present 0x00100073 (EBREAK) and 0x30002073 (CSR) -> no done.
- Timeout: TIMEOUT_CYCLES=20, inst_valid every cycle, no ECALL -> timeout=1 and done=1 after cycle_count hits 19. Separately, an ECALL exactly at count 19 -> PASS/FAIL, timeout=0.
- Reset mid-run: assert reset asynchronously between edges during RUN at instret_count=10 -> all outputs 0 immediately. On release, state=IDLE until the next inst_valid.
- With RV_MON_REGSHADOW_EN: write x5=0xDEADBEEF and x0=0x1234 -> dbg_sel=5 gives 0xDEADBEEF, dbg_sel=0 gives 0.
